pattern_tx: RTL

PATTERN_TX -- requirements
Module: pattern_tx

---
 rtl/pattern_tx_pkg.sv | 24 ++
 rtl/pattern_tx_shifter.sv | 57 +++++
 rtl/pattern_tx.sv | 115 +++++++++++
 3 files changed

// File: rtl/pattern_tx_pkg.sv
// pattern_tx_pkg -- shared definitions for the pattern_tx serialiser.
//   state_e     : FSM encoding (IDLE, SHIFT, GAP); the value 2'd3 is unused.
//   PARITY_EN   : 1 when the build appends an odd-parity bit to every frame
//                 (enabled by defining the macro PATTERN_TX_PARITY_EN).
//   PARITY_BITS : number of extra bits per frame contributed by parity.
//   GAP_CNT_W   : width of the inter-word gap counter (GAP_CYCLES <= 15).
package pattern_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

`ifdef PATTERN_TX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int PARITY_BITS = PARITY_EN ? 1 : 0;
    localparam int GAP_CNT_W   = 4;

endpackage

// File: rtl/pattern_tx_shifter.sv
// pattern_tx_shifter -- loadable MSB-first shift register with bit counter.
// Holds one frame (the data word, plus an odd-parity bit when the build
// defines PATTERN_TX_PARITY_EN) and flags the cycle that presents the last bit.
// Ports:
//   clk       in  clock, rising edge
//   rstN      in  asynchronous active-low reset, clears register and counter
//   load      in  capture load_data (and its parity) and restart the count
//   shift     in  advance one bit towards the MSB end
//   load_data in  [WIDTH] word to be framed
//   bit_out   out current frame bit (MSB of the register)
//   last      out bit_out is the final bit of the frame
module pattern_tx_shifter
    import pattern_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             bit_out,
    output logic             last
);

    localparam int FRAME_BITS = WIDTH + PARITY_BITS;
    // Sized to hold FRAME_BITS itself, so the final shift never wraps.
    localparam int CNT_W      = $clog2(WIDTH + 2);

    logic [FRAME_BITS-1:0] sreg;
    logic [FRAME_BITS-1:0] load_word;
    logic [CNT_W-1:0]      cnt;

`ifdef PATTERN_TX_PARITY_EN
    // Odd parity: total ones across data and parity bit is odd.
    assign load_word = {load_data, ~(^load_data)};
`else
    assign load_word = load_data;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= load_word;
            cnt  <= '0;
        end else if (shift) begin
            sreg <= {sreg[FRAME_BITS-2:0], 1'b0};
            cnt  <= cnt + CNT_W'(1);
        end
    end

    assign bit_out = sreg[FRAME_BITS-1];
    assign last    = (cnt == CNT_W'(FRAME_BITS - 1));

endmodule

// File: rtl/pattern_tx.sv
// pattern_tx -- Moore-style word serialiser with an idle-low gap after each word.
// A word offered with valid while ready is high is captured and sent MSB first,
// one bit per cycle starting the cycle after acceptance, followed by GAP_CYCLES
// low cycles; done pulses in the final gap cycle. Optional PATTERN_TX_PARITY_EN
// appends an odd-parity bit after data[0].
// Ports:
//   clk   in  clock, rising edge
//   rstN  in  asynchronous active-low reset; aborts any word in flight
//   valid in  data word offered
//   data  in  [WIDTH] word to serialise
//   ready out block accepts a word this cycle (IDLE, and not during reset)
//   out   out serial bit stream, low whenever no frame bit is presented
//   busy  out word in flight, including its gap
//   done  out one-cycle pulse in the final gap cycle
// Handshake: a word transfers on a rising edge where valid and ready are both
// high; ready depends only on registered state, and valid/data are ignored
// while busy.
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             valid,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             out,
    output logic             busy,
    output logic             done
);

    if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
        $error("pattern_tx: GAP_CYCLES must be in 1..15");
    end
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("pattern_tx: WIDTH must be in 2..32");
    end

    state_e               state_q;
    state_e               state_d;
    logic                 ready_en;   // low in reset, high from first edge after release
    logic [GAP_CNT_W-1:0] gap_q;
    logic                 load;
    logic                 shift;
    logic                 bit_out;
    logic                 last;
    logic                 gap_last;

    pattern_tx_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk       (clk),
        .rstN      (rstN),
        .load      (load),
        .shift     (shift),
        .load_data (data),
        .bit_out   (bit_out),
        .last      (last)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= IDLE;
            ready_en <= 1'b0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            ready_en <= 1'b1;
            gap_q    <= (state_q == GAP) ? gap_q + GAP_CNT_W'(1) : '0;
        end
    end

    assign gap_last = (gap_q == GAP_CNT_W'(GAP_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        ready   = 1'b0;
        out     = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                ready = ready_en;
                if (valid && ready_en) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy  = 1'b1;
                out   = bit_out;
                shift = 1'b1;
                if (last) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                busy = 1'b1;
                done = gap_last;
                if (gap_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                // Unencoded value: quiet outputs, recover to IDLE.
                state_d = IDLE;
            end
        endcase
    end

endmodule
